// File: rtl/fetch_pkg.sv
// +----------------------------------------------------------------------+
// | fetch_pkg : shared types, state encoding and default parameters      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [15:0] block_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FLUSH  = 2'd2,
    S_HALTED = 2'd3
  } fetch_state_e;

  localparam addr_t FETCH_RESET_VECTOR = 16'h0000;
  localparam int    FETCH_FLUSH_CYCLES = 2;

endpackage

`default_nettype wire

// File: rtl/fetch_if.sv
// +----------------------------------------------------------------------+
// | fetch_if : control inputs from execute and fetch outputs             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface fetch_if;
  import fetch_pkg::*;

  logic  start;
  logic  stall;
  logic  do_branch;
  addr_t branch_address;
  logic  do_halt;
  addr_t pc;
  logic  fetch_valid;
  logic  flush;
  logic  halted;

  modport master (
    output start, stall, do_branch, branch_address, do_halt,
    input  pc, fetch_valid, flush, halted
  );

  modport slave (
    input  start, stall, do_branch, branch_address, do_halt,
    output pc, fetch_valid, flush, halted
  );

endinterface

`default_nettype wire

// File: rtl/fetch_pc_counter.sv
// +----------------------------------------------------------------------+
// | fetch_pc_counter : program counter with load, hold, wrapping incr.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_pc_counter
  import fetch_pkg::*;
#(
  parameter addr_t RESET_VECTOR = FETCH_RESET_VECTOR
) (
  input  wire   clk,
  input  wire   rst,
  input  wire   load_i,
  input  addr_t load_value_i,
  input  wire   inc_i,
  output addr_t pc_o
);

  addr_t pc_q;
  addr_t pc_d;

  // Load has priority; the 16-bit add wraps 16'hFFFF to 16'h0000 naturally.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_value_i;
    end else if (inc_i) begin
      pc_d = pc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch.sv
// +----------------------------------------------------------------------+
// | fetch : instruction fetch sequencer (IDLE/RUN/FLUSH/HALTED)          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch
  import fetch_pkg::*;
#(
  parameter addr_t RESET_VECTOR = FETCH_RESET_VECTOR,
  parameter int    FLUSH_CYCLES = FETCH_FLUSH_CYCLES
) (
  input  wire     clk,
  input  wire     rst,
  fetch_if.slave  bus
);

  fetch_state_e state_q, state_d;
  logic [1:0]   flush_cnt_q, flush_cnt_d;
  logic         fetch_valid_q, fetch_valid_d;
  logic         flush_q, flush_d;
  logic         halted_q, halted_d;
  logic         pc_load;
  addr_t        pc_load_value;
  logic         pc_inc;
  addr_t        pc;

  fetch_pc_counter #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_counter (
    .clk          (clk),
    .rst          (rst),
    .load_i       (pc_load),
    .load_value_i (pc_load_value),
    .inc_i        (pc_inc),
    .pc_o         (pc)
  );

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    fetch_valid_d = fetch_valid_q;
    flush_d       = flush_q;
    halted_d      = halted_q;
    pc_load       = 1'b0;
    pc_load_value = bus.branch_address;
    pc_inc        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        fetch_valid_d = 1'b0;
        flush_d       = 1'b0;
        if (bus.start) begin
          state_d       = S_RUN;
          pc_load       = 1'b1;
          pc_load_value = RESET_VECTOR;
          fetch_valid_d = 1'b1;
        end
      end
      S_RUN: begin
        // Halt outranks branch, and both outrank stall.
        if (bus.do_halt) begin
          state_d       = S_HALTED;
          halted_d      = 1'b1;
          fetch_valid_d = 1'b0;
          flush_d       = 1'b0;
        end else if (bus.do_branch) begin
          state_d       = S_FLUSH;
          pc_load       = 1'b1;
          fetch_valid_d = 1'b1;
          flush_d       = 1'b1;
          flush_cnt_d   = 2'(FLUSH_CYCLES - 1);
        end else begin
          pc_inc = !bus.stall;
        end
      end
      S_FLUSH: begin
        // Branch/halt seen here come from squashed instructions.
        pc_inc        = !bus.stall;
        fetch_valid_d = 1'b1;
        if (flush_cnt_q == 2'd0) begin
          flush_d = 1'b0;
          state_d = S_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 2'd1;
        end
      end
      S_HALTED: begin
        fetch_valid_d = 1'b0;
        flush_d       = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      flush_cnt_q   <= 2'd0;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      halted_q      <= halted_d;
    end
  end

  assign bus.pc          = pc;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.flush       = flush_q;
  assign bus.halted      = halted_q;

endmodule

`default_nettype wire
